// File: rtl/conv_result_streamer_if.sv
// rtl/conv_result_streamer_if.sv - result-memory read port and output stream bundle
//
// Purpose: groups the result-memory read port and the narrowed output stream
// of conv_result_streamer.
// Signals:
//   mem_rd_en / mem_addr : read strobe and address toward the result memory
//   mem_data             : read data, valid the cycle after mem_rd_en
//   m_data / m_valid / m_ready / m_last : output word stream
// Modports: master = streamer side, slave = memory + consumer side.

interface conv_result_streamer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int OUT_WIDTH  = 16
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [OUT_WIDTH-1:0]  m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_data,
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_data,
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - drains the convolution result memory onto a valid/ready stream
//
// Purpose: on start, reads result words 0..len-1 (len = size_x + size_y - 1)
// through a 2-entry FIFO and streams them narrowed to OUT_WIDTH bits.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : transfer request, honoured only while idle
//   size_x, size_y  : input lengths, sampled with an accepted start
//   busy, done      : transfer in progress / one-cycle completion pulse
//   bus (master)    : result-memory read port and output stream
// Optional macro CONV_STREAM_SAT_EN: signed saturation instead of truncation.

module conv_result_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [5:0]            size_x,
   input  logic [5:0]            size_y,
   output logic                  busy,
   output logic                  done,
   conv_result_streamer_if.master bus
);

`ifdef CONV_STREAM_SAT_EN
   // Saturation needs the full signed word at the FIFO head.
   localparam int FIFO_W = DATA_WIDTH;
`else
   // Truncation only ever looks at the low bits, so only those are stored.
   localparam int FIFO_W = OUT_WIDTH;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state;
   logic [6:0]          len;
   logic [6:0]          len_m1;
   logic [6:0]          start_len;
   logic [6:0]          rd_ptr;
   logic [6:0]          out_cnt;
   logic [FIFO_W-1:0]   fifo_mem [2];
   logic                fifo_wr_idx;
   logic                fifo_rd_idx;
   logic [1:0]          fifo_cnt;
   logic                rd_pending;   // read issued last cycle; its data is on mem_data now
   logic [FIFO_W-1:0]   head;
   logic                pop;
   logic                issue;

   always_comb begin
      start_len = 7'd0;
      if (size_x != 6'd0 && size_y != 6'd0)
         start_len = {1'b0, size_x} + {1'b0, size_y} - 7'd1;
   end

   assign len_m1 = len - 7'd1;
   assign head   = fifo_mem[fifo_rd_idx];
   assign pop    = bus.m_valid & bus.m_ready;

   // Slots already committed (stored + arriving this cycle) minus the word
   // leaving this cycle must leave room for the word this read will return.
   assign issue = (state == S_RUN) && (rd_ptr < len) &&
                  (({1'b0, fifo_cnt} + {2'b00, rd_pending} - {2'b00, pop}) < 3'd2);

   assign bus.mem_rd_en = issue;
   assign bus.mem_addr  = ADDR_WIDTH'(rd_ptr);
   assign bus.m_valid   = (fifo_cnt != 2'd0);
   assign bus.m_last    = bus.m_valid && (out_cnt == len_m1);
   assign busy          = (state == S_RUN);
   assign done          = (state == S_DONE);

`ifdef CONV_STREAM_SAT_EN
   localparam int HI_W = DATA_WIDTH - OUT_WIDTH + 1;
   logic [HI_W-1:0] head_hi;

   // The word fits when every bit from the output sign bit upward matches.
   always_comb begin
      head_hi = head[DATA_WIDTH-1:OUT_WIDTH-1];
      if (head_hi == '0 || head_hi == '1)
         bus.m_data = head[OUT_WIDTH-1:0];
      else if (head[DATA_WIDTH-1])
         bus.m_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         bus.m_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end
`else
   assign bus.m_data = head;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         len         <= 7'd0;
         rd_ptr      <= 7'd0;
         out_cnt     <= 7'd0;
         fifo_wr_idx <= 1'b0;
         fifo_rd_idx <= 1'b0;
         fifo_cnt    <= 2'd0;
         rd_pending  <= 1'b0;
         for (int i = 0; i < 2; i++)
            fifo_mem[i] <= '0;
      end else begin
         rd_pending <= issue;
         if (issue)
            rd_ptr <= rd_ptr + 7'd1;
         if (rd_pending) begin
            fifo_mem[fifo_wr_idx] <= bus.mem_data[FIFO_W-1:0];
            fifo_wr_idx           <= ~fifo_wr_idx;
         end
         if (pop) begin
            fifo_rd_idx <= ~fifo_rd_idx;
            out_cnt     <= out_cnt + 7'd1;
         end
         fifo_cnt <= fifo_cnt + {1'b0, rd_pending} - {1'b0, pop};

         case (state)
            S_IDLE: begin
               if (start) begin
                  len     <= start_len;
                  rd_ptr  <= 7'd0;
                  out_cnt <= 7'd0;
                  state   <= (start_len != 7'd0) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               if (pop && out_cnt == len_m1)
                  state <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
